// File: rtl/sub72_nibble_serial.sv
// Digit-serial subtractor: diff = a - b - bin, one DIGIT-bit slice per cycle, LSB first.
// Operands and results move over valid/ready handshakes.
module sub72_nibble_serial #(
   parameter int WIDTH = 72,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG + 1) : 1;

   if (WIDTH % DIGIT != 0) begin : g_width_check
      $error("sub72_nibble_serial: WIDTH must be a multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
   logic [CW-1:0]    cnt_q;
   logic             br_q, bout_q, zero_q, ovf_q;
   logic             in_ready_q, out_valid_q;

   logic [DIGIT-1:0] a_dig, b_dig, d;
   logic [DIGIT:0]   sum;
   logic             br, last;

   // One slice of the borrow chain: a - b - borrow == a + ~b + ~borrow, borrow out = ~carry out.
   always_comb begin
      // NOTE: every signal gets a default before the loop so no latch is inferred.
      a_dig  = '0;
      b_dig  = '0;
      diff_d = diff_q;
      for (int i = 0; i < NDIG; i++) begin
         if (cnt_q == CW'(i)) begin
            a_dig = a_q[i*DIGIT +: DIGIT];
            b_dig = b_q[i*DIGIT +: DIGIT];
         end
      end
      sum = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, ~br_q};
      d   = sum[DIGIT-1:0];
      br  = ~sum[DIGIT];
      for (int i = 0; i < NDIG; i++) begin
         if (cnt_q == CW'(i)) diff_d[i*DIGIT +: DIGIT] = d;
      end
      last = (cnt_q == CW'(NDIG - 1));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         br_q        <= 1'b0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  br_q       <= bin;
                  cnt_q      <= '0;
                  diff_q     <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               diff_q <= diff_d;
               br_q   <= br;
               cnt_q  <= cnt_q + CW'(1);
               if (last) begin
                  bout_q      <= br;
                  zero_q      <= (diff_d == '0);
                  ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               // Drain only; a new operand set is taken no earlier than the following cycle.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub72_nibble_serial.sv
// Directed bench for sub72_nibble_serial: expected results are queued at accept
// and compared when out_valid appears.
module tb_sub72_nibble_serial;

   localparam int W = 72;
   localparam int LAT = 18;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout, zero, ovf;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         zero;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   sub72_nibble_serial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      exp_t       e;
      logic [W:0] full;
      full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      e.diff = full[W-1:0];
      e.bout = full[W];
      e.zero = (e.diff == '0);
      e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      int n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check("in_ready_before_accept", in_ready, 1'b1);
      a        = ta;
      b        = tb;
      bin      = tbin;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      sb_q.push_back(model(ta, tb, tbin));
      check("in_ready_low_in_run", in_ready, 1'b0);
   endtask

   task automatic wait_result(input string tag);
      int   n = 0;
      exp_t e;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      check({tag, "_latency"}, n, LAT);
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_diff"}, diff, e.diff);
         check({tag, "_bout"}, bout, e.bout);
         check({tag, "_zero"}, zero, e.zero);
         check({tag, "_ovf"},  ovf,  e.ovf);
      end
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_out_valid_cleared"}, out_valid, 1'b0);
      check({tag, "_in_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] pat;
      logic [W-1:0] held;
      int           seen;
      ones = '1;
      pat  = 72'h12_3456_789A_BCDE_F012;

      #12;
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_diff", diff, '0);
      check("reset_flags", {bout, zero, ovf}, 3'b000);
      rst_n = 1'b1;
      step();

      // 1: small positive difference
      accept(72'd5, 72'd3, 1'b0);
      wait_result("t1");
      drain("t1");
      check("t1_result_kept", diff, 72'd2);

      // 2: borrow ripples through every digit
      accept(72'd0, 72'd1, 1'b0);
      wait_result("t2");
      drain("t2");

      // 3: equal operands with and without borrow-in
      accept(pat, pat, 1'b0);
      wait_result("t3a");
      drain("t3a");
      accept(pat, pat, 1'b1);
      wait_result("t3b");
      check("t3b_all_ones", diff, ones);
      drain("t3b");

      // 4: signed overflow, max positive minus min negative
      accept(72'h7F_FFFF_FFFF_FFFF_FFFF, 72'h80_0000_0000_0000_0000, 1'b0);
      wait_result("t4");
      drain("t4");

      // 5: backpressure holds the result and blocks new operands
      accept(72'h55_0000_0000_0000_1234, 72'h11_0000_0000_0000_0234, 1'b0);
      wait_result("t5");
      held     = diff;
      a        = 72'd99;
      b        = 72'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t5_diff_stable", diff, held);
         check("t5_in_ready_low", in_ready, 1'b0);
         check("t5_out_valid_held", out_valid, 1'b1);
      end
      in_valid = 1'b0;
      drain("t5");
      check("t5_result_kept", diff, held);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (out_valid) seen++;
      end
      check("t5_ignored_in_valid", seen, 0);

      // 6: asynchronous reset mid-run at cnt=9
      accept(72'd5, 72'd3, 1'b0);
      repeat (9) step();
      #2 rst_n = 1'b0;
      #1;
      check("t6_out_valid_reset", out_valid, 1'b0);
      check("t6_diff_reset", diff, '0);
      check("t6_flags_reset", {bout, zero, ovf}, 3'b000);
      check("t6_in_ready_reset", in_ready, 1'b1);
      void'(sb_q.pop_back());
      step();
      #2 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (out_valid) seen++;
      end
      check("t6_no_stale_result", seen, 0);
      check("t6_in_ready_after", in_ready, 1'b1);
      accept(72'd5, 72'd3, 1'b0);
      wait_result("t6_repeat");
      drain("t6_repeat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
